// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for three ultrasonic ranging sensors: triggers each sensor in turn,
// times its echo pulse in centimetres, and publishes per-sensor distance/near/timeout status.
`timescale 1ns/1ps

module ultrasonic_scheduler #(
    parameter int TRIG_CYCLES    = 500,
    parameter int CYCLES_PER_CM  = 2900,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GAP_CYCLES     = 500000,
    parameter int WARN_CM        = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [2:0]  echo,
    output logic [2:0]  trig,
    output logic [26:0] dist_cm,
    output logic [2:0]  near,
    output logic [2:0]  timeout,
    output logic        valid,
    output logic [1:0]  valid_idx,
    output logic        buzzer
);

    // One phase counter serves TRIG width, the echo timeout and the GAP length.
    localparam int CNT_MAX_A = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int SUB_W     = (CYCLES_PER_CM > 1) ? $clog2(CYCLES_PER_CM) : 1;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clear;
    logic [2:0]       echo_meta;
    logic [2:0]       echo_sync;
    logic             echo_sel;
    logic             armed;
    logic [SUB_W-1:0] sub_cnt;
    logic [8:0]       cm_cnt;
    logic             cm_step;
    logic             meas_done;
    logic             meas_to;
    logic             wr_q;
    logic [1:0]       wr_idx;
    logic             trig_last;
    logic             to_hit;
    logic             gap_done;

    assign echo_sel  = echo_sync[idx];
    assign trig_last = (cnt == CNT_W'(TRIG_CYCLES - 1));
    assign to_hit    = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign gap_done  = (cnt == CNT_W'(GAP_CYCLES - 1));
    assign buzzer    = |near;

    // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // trig decodes straight from the state register, so an asynchronous reset drops it at once.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_next = state;
        trig       = '0;
        cm_step    = 1'b0;
        meas_done  = 1'b0;
        meas_to    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_next = TRIG;
            end
            TRIG: begin
                trig[idx] = 1'b1;
                if (trig_last) state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (to_hit) begin
                    meas_to    = 1'b1;
                    state_next = GAP;
                end else if (armed && echo_sel) begin
                    // The rising cycle is itself the first echo-high cycle.
                    cm_step    = 1'b1;
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (!echo_sel) begin
                    meas_done  = 1'b1;
                    state_next = GAP;
                end else if (to_hit) begin
                    meas_to    = 1'b1;
                    state_next = GAP;
                end else begin
                    cm_step = 1'b1;
                end
            end
            GAP: begin
                if (gap_done) state_next = enable ? TRIG : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The timeout window spans WAIT_RISE and MEASURE, so that transition keeps counting.
    assign cnt_clear = (state_next != state) && !(state == WAIT_RISE && state_next == MEASURE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_meta <= '0;
            echo_sync <= '0;
            cnt       <= '0;
            armed     <= 1'b0;
            sub_cnt   <= '0;
            cm_cnt    <= '0;
            idx       <= 2'd0;
            dist_cm   <= '1;
            near      <= '0;
            timeout   <= '0;
            wr_q      <= 1'b0;
            wr_idx    <= 2'd0;
            valid     <= 1'b0;
            valid_idx <= 2'd0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;

            if (state == IDLE || cnt_clear) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A rise only counts after the selected echo has been seen low inside WAIT_RISE.
            if (state == TRIG) begin
                armed <= 1'b0;
            end else if (state == WAIT_RISE && !echo_sel) begin
                armed <= 1'b1;
            end

            if (state == TRIG) begin
                sub_cnt <= '0;
                cm_cnt  <= '0;
            end else if (cm_step) begin
                if (sub_cnt == SUB_W'(CYCLES_PER_CM - 1)) begin
                    sub_cnt <= '0;
                    if (cm_cnt != 9'd511) cm_cnt <= cm_cnt + 9'd1;
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end

            if (meas_done) begin
                dist_cm[9*idx +: 9] <= cm_cnt;
                timeout[idx]        <= 1'b0;
                near[idx]           <= (cm_cnt < 9'(WARN_CM));
            end else if (meas_to) begin
                dist_cm[9*idx +: 9] <= 9'd511;
                timeout[idx]        <= 1'b1;
                near[idx]           <= 1'b0;
            end

            wr_q      <= meas_done | meas_to;
            wr_idx    <= idx;
            valid     <= wr_q;
            if (wr_q) valid_idx <= wr_idx;

            if (state == GAP && gap_done) begin
                idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler with small timing parameters and hand-computed results.
`timescale 1ns/1ps

module tb_ultrasonic_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [2:0]  echo;
    logic [2:0]  trig;
    logic [26:0] dist_cm;
    logic [2:0]  near;
    logic [2:0]  timeout;
    logic        valid;
    logic [1:0]  valid_idx;
    logic        buzzer;

    int n_checks = 0;
    int n_fail   = 0;
    int onehot_bad = 0;

    ultrasonic_scheduler #(
        .TRIG_CYCLES   (4),
        .CYCLES_PER_CM (2),
        .TIMEOUT_CYCLES(200),
        .GAP_CYCLES    (10),
        .WARN_CM       (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .echo     (echo),
        .trig     (trig),
        .dist_cm  (dist_cm),
        .near     (near),
        .timeout  (timeout),
        .valid    (valid),
        .valid_idx(valid_idx),
        .buzzer   (buzzer)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((trig & (trig - 3'd1)) != 3'd0) onehot_bad++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [8:0] field(input int i);
        return dist_cm[9*i +: 9];
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_trig(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (trig != 3'd0) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_trig_low(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (trig == 3'd0) break;
            tick(1);
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic echo_pulse(input int sensor, input int high_cycles);
        echo[sensor] = 1'b1;
        tick(high_cycles);
        echo[sensor] = 1'b0;
    endtask

    initial begin
        int width;
        int trig_seen;

        rst    = 1'b1;
        enable = 1'b0;
        echo   = 3'b000;
        tick(3);
        check("rst_trig",      32'(trig),      32'd0);
        check("rst_valid",     32'(valid),     32'd0);
        check("rst_valid_idx", 32'(valid_idx), 32'd0);
        check("rst_dist",      32'(dist_cm),   32'h7FF_FFFF);
        check("rst_near",      32'(near),      32'd0);
        check("rst_timeout",   32'(timeout),   32'd0);
        check("rst_buzzer",    32'(buzzer),    32'd0);

        // Slot 0: 20-cycle echo, with foreign echo[2] activity during the slot.
        rst    = 1'b0;
        enable = 1'b1;
        wait_trig("s0_trig", 20);
        check("s0_trig_sel", 32'(trig), 32'd1);
        echo[2] = 1'b1;
        width = 1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (trig == 3'b001) width++;
            else break;
        end
        check("s0_trig_width", 32'(width), 32'd4);
        tick(3);
        echo_pulse(0, 20);
        wait_valid("s0_valid", 300);
        check("s0_valid_idx", 32'(valid_idx), 32'd0);
        check("s0_dist",      32'(field(0)),  32'd10);
        check("s0_near",      32'(near[0]),   32'd0);
        check("s0_timeout",   32'(timeout[0]), 32'd0);
        tick(1);
        check("s0_valid_pulse", 32'(valid), 32'd0);
        echo[2] = 1'b0;

        // Slot 1: 6-cycle echo -> 3 cm, below threshold.
        wait_trig("s1_trig", 50);
        check("s1_trig_sel", 32'(trig), 32'd2);
        wait_trig_low(20);
        tick(3);
        echo_pulse(1, 6);
        wait_valid("s1_valid", 300);
        check("s1_valid_idx", 32'(valid_idx), 32'd1);
        check("s1_dist",      32'(field(1)),  32'd3);
        check("s1_near",      32'(near),      32'b010);
        check("s1_buzzer",    32'(buzzer),    32'd1);

        // Slot 2: echo never rises -> timeout.
        wait_trig("s2_trig", 50);
        check("s2_trig_sel", 32'(trig), 32'd4);
        wait_valid("s2_valid", 400);
        check("s2_valid_idx", 32'(valid_idx), 32'd2);
        check("s2_dist",      32'(field(2)),  32'd511);
        check("s2_timeout",   32'(timeout),   32'b100);
        check("s2_near",      32'(near),      32'b010);
        check("s2_dist0_kept", 32'(field(0)), 32'd10);

        // Slot 0 again: 10-cycle echo -> exactly WARN_CM, near stays low.
        wait_trig("s0b_trig", 50);
        check("s0b_trig_sel", 32'(trig), 32'd1);
        wait_trig_low(20);
        tick(3);
        echo_pulse(0, 10);
        wait_valid("s0b_valid", 300);
        check("s0b_dist", 32'(field(0)), 32'd5);
        check("s0b_near", 32'(near),     32'b010);

        // Slot 1 again: enable drops mid-measurement; slot must still complete.
        wait_trig("s1b_trig", 50);
        check("s1b_trig_sel", 32'(trig), 32'd2);
        wait_trig_low(20);
        tick(3);
        echo[1] = 1'b1;
        tick(5);
        enable = 1'b0;
        tick(3);
        echo[1] = 1'b0;
        wait_valid("s1b_valid", 300);
        check("s1b_valid_idx", 32'(valid_idx), 32'd1);
        check("s1b_dist",      32'(field(1)),  32'd4);
        check("s1b_near",      32'(near),      32'b010);
        trig_seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (trig != 3'd0) trig_seen++;
        end
        check("idle_no_trig", 32'(trig_seen), 32'd0);

        // Resume on sensor 2, then reset asynchronously during its trigger pulse.
        enable = 1'b1;
        wait_trig("s2b_trig", 20);
        check("s2b_trig_sel", 32'(trig), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_trig",      32'(trig),      32'd0);
        check("arst_dist",      32'(dist_cm),   32'h7FF_FFFF);
        check("arst_timeout",   32'(timeout),   32'd0);
        check("arst_near",      32'(near),      32'd0);
        check("arst_buzzer",    32'(buzzer),    32'd0);
        check("arst_valid_idx", 32'(valid_idx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_trig("post_rst_trig", 20);
        check("post_rst_trig_sel", 32'(trig), 32'd1);

        check("trig_onehot", 32'(onehot_bad), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
